// File: rtl/bpu_pkg.sv
// Shared types for the branch prediction unit: one-hot branch op, grouped
// port structs for the default configuration, BTB entry layout and the
// 2-bit saturating counter step.
package bpu_pkg;

  localparam int BPU_XLEN      = 32;
  localparam int BPU_BTB_DEPTH = 64;
  localparam int BPU_IDX_W     = $clog2(BPU_BTB_DEPTH);
  localparam int BPU_TAG_W     = BPU_XLEN - BPU_IDX_W - 2;

  typedef struct packed {
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic bltu;
    logic bgeu;
  } bcu_op_type;

  typedef struct packed {
    logic                flush;
    logic                pred_valid;
    logic [BPU_XLEN-1:0] pred_pc;
    logic                res_valid;
    bcu_op_type          res_op;
    logic [BPU_XLEN-1:0] res_pc;
    logic [BPU_XLEN-1:0] res_target;
    logic [BPU_XLEN-1:0] rdata1;
    logic [BPU_XLEN-1:0] rdata2;
    logic                res_pred_taken;
    logic [BPU_XLEN-1:0] res_pred_target;
  } bpu_in_type;

  typedef struct packed {
    logic                pred_rvalid;
    logic                pred_taken;
    logic [BPU_XLEN-1:0] pred_target;
    logic                res_done;
    logic                res_taken;
    logic                res_mispredict;
    logic [BPU_XLEN-1:0] res_redirect_pc;
    logic [31:0]         mispredict_cnt;
  } bpu_out_type;

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [BPU_XLEN-1:0]  target;
    logic [1:0]           cnt;
  } btb_entry_type;

  // One training step of the 2-bit counter, saturating at 0 and 3.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/bpu_if.sv
// Fetch/execute facing bundle of the branch prediction unit. The pipeline
// side uses the master modport, the bpu itself the slave modport.
interface bpu_if
  import bpu_pkg::*;
#(
  parameter int XLEN = BPU_XLEN
) ();

  logic            flush;
  logic            pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic            pred_rvalid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            res_valid;
  bcu_op_type      res_op;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            res_pred_taken;
  logic [XLEN-1:0] res_pred_target;
  logic            res_done;
  logic            res_taken;
  logic            res_mispredict;
  logic [XLEN-1:0] res_redirect_pc;
  logic [31:0]     mispredict_cnt;

  modport master (
    output flush, pred_valid, pred_pc,
    output res_valid, res_op, res_pc, res_target, rdata1, rdata2,
    output res_pred_taken, res_pred_target,
    input  pred_rvalid, pred_taken, pred_target,
    input  res_done, res_taken, res_mispredict, res_redirect_pc, mispredict_cnt
  );

  modport slave (
    input  flush, pred_valid, pred_pc,
    input  res_valid, res_op, res_pc, res_target, rdata1, rdata2,
    input  res_pred_taken, res_pred_target,
    output pred_rvalid, pred_taken, pred_target,
    output res_done, res_taken, res_mispredict, res_redirect_pc, mispredict_cnt
  );

endinterface

// File: rtl/bpu_btb_ram.sv
// Direct-mapped BTB storage: registered read port for fetch, one write port
// for training, plus a combinational view of the entry at the write index so
// the trainer can do read-modify-write in a single cycle.
// Macro BPU_FWD_EN: when defined, a same-cycle write to the read index is
// forwarded into the read register; otherwise the read sees the old entry.
module bpu_btb_ram #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int TAG_W = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [XLEN-1:0]  o_rd_target,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [XLEN-1:0]  i_wr_target,
  input  logic [1:0]       i_wr_cnt,
  output logic             o_wr_valid,
  output logic [TAG_W-1:0] o_wr_tag,
  output logic [XLEN-1:0]  o_wr_target,
  output logic [1:0]       o_wr_cnt
);

  logic             r_valid  [DEPTH];
  logic [1:0]       r_cnt    [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];

  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [XLEN-1:0]  w_rd_target;
  logic [1:0]       w_rd_cnt;

  // Valid bits and counters clear asynchronously; a write always validates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= 2'b01;
      end
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_cnt[i_wr_idx]   <= i_wr_cnt;
    end
  end

  // Tag and target need no reset: they are ignored while the entry is invalid.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end

  assign o_wr_valid  = r_valid[i_wr_idx];
  assign o_wr_tag    = r_tag[i_wr_idx];
  assign o_wr_target = r_target[i_wr_idx];
  assign o_wr_cnt    = r_cnt[i_wr_idx];

  // Select read data, optionally bypassing the entry being written this cycle.
  always_comb begin
    w_rd_valid  = r_valid[i_rd_idx];
    w_rd_tag    = r_tag[i_rd_idx];
    w_rd_target = r_target[i_rd_idx];
    w_rd_cnt    = r_cnt[i_rd_idx];
`ifdef BPU_FWD_EN
    if (i_wr_en && (i_wr_idx == i_rd_idx)) begin
      w_rd_valid  = 1'b1;
      w_rd_tag    = i_wr_tag;
      w_rd_target = i_wr_target;
      w_rd_cnt    = i_wr_cnt;
    end
`endif
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_valid  <= 1'b0;
      o_rd_tag    <= '0;
      o_rd_target <= '0;
      o_rd_cnt    <= 2'b01;
    end else if (i_rd_en) begin
      o_rd_valid  <= w_rd_valid;
      o_rd_tag    <= w_rd_tag;
      o_rd_target <= w_rd_target;
      o_rd_cnt    <= w_rd_cnt;
    end
  end

endmodule

// File: rtl/bpu.sv
// Branch prediction and resolution unit. Fetch queries the BTB and gets a
// prediction one cycle later; execute resolves branches, trains the BTB and
// gets a registered mispredict/redirect one cycle later.
// Same-index query/resolve behaviour is selected by macro BPU_FWD_EN (see
// bpu_btb_ram).
module bpu
  import bpu_pkg::*;
#(
  parameter int          XLEN      = BPU_XLEN,
  parameter int          BTB_DEPTH = BPU_BTB_DEPTH,
  parameter logic [31:0] CNT_MAX   = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic rst,
  bpu_if.slave io_bpu
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             r_pred_rvalid;
  logic [XLEN-1:0]  r_pred_pc;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [XLEN-1:0]  w_rd_target;
  logic [1:0]       w_rd_cnt;
  logic             w_pred_taken;

  logic             w_op_any;
  logic             w_eq;
  logic             w_lt;
  logic             w_ltu;
  logic             w_taken;
  logic             w_mispredict;
  logic [XLEN-1:0]  w_redirect;
  logic [IDX_W-1:0] w_res_idx;
  logic [TAG_W-1:0] w_res_tag;
  logic             w_ent_valid;
  logic [TAG_W-1:0] w_ent_tag;
  logic [XLEN-1:0]  w_ent_target;
  logic [1:0]       w_ent_cnt;
  logic             w_res_hit;
  logic             w_wr_en;
  logic [1:0]       w_wr_cnt;
  logic [XLEN-1:0]  w_wr_target;

  logic             r_res_done;
  logic             r_res_taken;
  logic             r_res_mispredict;
  logic [XLEN-1:0]  r_res_redirect;
  logic [31:0]      r_mispredict_cnt;

  bpu_btb_ram #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_rd_en     (io_bpu.pred_valid),
    .i_rd_idx    (io_bpu.pred_pc[IDX_W+1:2]),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_target (w_rd_target),
    .o_rd_cnt    (w_rd_cnt),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_res_idx),
    .i_wr_tag    (w_res_tag),
    .i_wr_target (w_wr_target),
    .i_wr_cnt    (w_wr_cnt),
    .o_wr_valid  (w_ent_valid),
    .o_wr_tag    (w_ent_tag),
    .o_wr_target (w_ent_target),
    .o_wr_cnt    (w_ent_cnt)
  );

  // Query pipeline register; flush kills the query being accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_rvalid <= 1'b0;
      r_pred_pc     <= '0;
    end else begin
      r_pred_rvalid <= io_bpu.pred_valid & ~io_bpu.flush;
      if (io_bpu.pred_valid) r_pred_pc <= io_bpu.pred_pc;
    end
  end

  // Prediction from the registered BTB read; outputs stay 0 when not valid.
  always_comb begin
    w_pred_taken = r_pred_rvalid && w_rd_valid &&
                   (w_rd_tag == r_pred_pc[XLEN-1:IDX_W+2]) && w_rd_cnt[1];
  end

  assign io_bpu.pred_rvalid = r_pred_rvalid;
  assign io_bpu.pred_taken  = w_pred_taken;
  assign io_bpu.pred_target = !r_pred_rvalid ? '0 :
                              (w_pred_taken ? w_rd_target : r_pred_pc + XLEN'(4));

  // Branch condition, mispredict and redirect evaluation.
  always_comb begin
    w_op_any     = |io_bpu.res_op;
    w_eq         = (io_bpu.rdata1 == io_bpu.rdata2);
    w_lt         = ($signed(io_bpu.rdata1) < $signed(io_bpu.rdata2));
    w_ltu        = (io_bpu.rdata1 < io_bpu.rdata2);
    w_taken      = (io_bpu.res_op.beq  &  w_eq)  | (io_bpu.res_op.bne  & ~w_eq)  |
                   (io_bpu.res_op.blt  &  w_lt)  | (io_bpu.res_op.bge  & ~w_lt)  |
                   (io_bpu.res_op.bltu &  w_ltu) | (io_bpu.res_op.bgeu & ~w_ltu);
    w_mispredict = w_op_any &&
                   ((w_taken != io_bpu.res_pred_taken) ||
                    (w_taken && (io_bpu.res_pred_target != io_bpu.res_target)));
    w_redirect   = w_taken ? io_bpu.res_target : io_bpu.res_pc + XLEN'(4);
  end

  // BTB training: bump counter on hit, allocate on taken miss, else leave alone.
  always_comb begin
    w_res_idx   = io_bpu.res_pc[IDX_W+1:2];
    w_res_tag   = io_bpu.res_pc[XLEN-1:IDX_W+2];
    w_res_hit   = w_ent_valid && (w_ent_tag == w_res_tag);
    w_wr_en     = io_bpu.res_valid && w_op_any && (w_res_hit || w_taken);
    w_wr_cnt    = w_res_hit ? cnt_next(w_ent_cnt, w_taken) : 2'b10;
    w_wr_target = w_taken ? io_bpu.res_target : w_ent_target;
  end

  // Registered resolve outputs and saturating mispredict counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_done       <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_redirect   <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      r_res_done       <= io_bpu.res_valid;
      r_res_taken      <= io_bpu.res_valid & w_taken;
      r_res_mispredict <= io_bpu.res_valid & w_mispredict;
      r_res_redirect   <= io_bpu.res_valid ? w_redirect : '0;
      if (io_bpu.res_valid && w_mispredict && (r_mispredict_cnt != CNT_MAX))
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign io_bpu.res_done        = r_res_done;
  assign io_bpu.res_taken       = r_res_taken;
  assign io_bpu.res_mispredict  = r_res_mispredict;
  assign io_bpu.res_redirect_pc = r_res_redirect;
  assign io_bpu.mispredict_cnt  = r_mispredict_cnt;

endmodule

// File: tb/tb_bpu.sv
// Directed bench for bpu with a per-cycle scoreboard of expected prediction
// and resolve results. Mispredict counter saturation uses CNT_MAX = 4.
module tb_bpu;
  import bpu_pkg::*;

  localparam logic [31:0] TB_CNT_MAX = 32'd4;
  localparam bcu_op_type OP_NONE = 6'b000000;
  localparam bcu_op_type OP_BEQ  = 6'b100000;
  localparam bcu_op_type OP_BNE  = 6'b010000;
  localparam bcu_op_type OP_BLT  = 6'b001000;
  localparam bcu_op_type OP_BGE  = 6'b000100;
  localparam bcu_op_type OP_BLTU = 6'b000010;
  localparam bcu_op_type OP_BGEU = 6'b000001;

  typedef struct {
    logic        vld;
    logic        taken;
    logic [31:0] target;
  } pred_exp_t;

  typedef struct {
    logic        done;
    logic        taken;
    logic        misp;
    logic [31:0] redirect;
    logic [31:0] cnt;
  } res_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpu_if #(.XLEN(32)) bus ();

  bpu #(
    .XLEN      (32),
    .BTB_DEPTH (64),
    .CNT_MAX   (TB_CNT_MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bpu (bus)
  );

  pred_exp_t   pred_q[$];
  res_exp_t    res_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m_cnt    = 32'd0;
  bit          q_pushed = 1'b0;
  bit          r_pushed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.flush           = 1'b0;
    bus.pred_valid      = 1'b0;
    bus.pred_pc         = '0;
    bus.res_valid       = 1'b0;
    bus.res_op          = OP_NONE;
    bus.res_pc          = '0;
    bus.res_target      = '0;
    bus.rdata1          = '0;
    bus.rdata2          = '0;
    bus.res_pred_taken  = 1'b0;
    bus.res_pred_target = '0;
  endtask

  task automatic query(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    pred_exp_t e;
    bus.pred_valid = 1'b1;
    bus.pred_pc    = pc;
    e.vld = 1'b1; e.taken = et; e.target = etgt;
    pred_q.push_back(e);
    q_pushed = 1'b1;
  endtask

  // et is the expected branch outcome; mispredict/redirect/count follow from it.
  task automatic resolve(input bcu_op_type op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt, input logic et);
    res_exp_t e;
    bus.res_valid       = 1'b1;
    bus.res_op          = op;
    bus.rdata1          = r1;
    bus.rdata2          = r2;
    bus.res_pc          = pc;
    bus.res_target      = tgt;
    bus.res_pred_taken  = pt;
    bus.res_pred_target = ptgt;
    e.done     = 1'b1;
    e.taken    = et;
    e.misp     = (op != OP_NONE) && ((et != pt) || (et && (ptgt != tgt)));
    e.redirect = et ? tgt : pc + 32'd4;
    if (e.misp && (m_cnt != TB_CNT_MAX)) m_cnt = m_cnt + 32'd1;
    e.cnt = m_cnt;
    res_q.push_back(e);
    r_pushed = 1'b1;
  endtask

  task automatic tick(input string tag);
    pred_exp_t pe;
    res_exp_t  re;
    if (!q_pushed) begin
      pe.vld = 1'b0; pe.taken = 1'b0; pe.target = '0;
      pred_q.push_back(pe);
    end
    if (!r_pushed) begin
      re.done = 1'b0; re.taken = 1'b0; re.misp = 1'b0; re.redirect = '0; re.cnt = m_cnt;
      res_q.push_back(re);
    end
    @(posedge clk);
    #1;
    pe = pred_q.pop_front();
    re = res_q.pop_front();
    chk({tag, ".pred_rvalid"}, 32'(bus.pred_rvalid), 32'(pe.vld));
    if (pe.vld) begin
      chk({tag, ".pred_taken"}, 32'(bus.pred_taken), 32'(pe.taken));
      chk({tag, ".pred_target"}, bus.pred_target, pe.target);
    end
    chk({tag, ".res_done"}, 32'(bus.res_done), 32'(re.done));
    if (re.done) begin
      chk({tag, ".res_taken"}, 32'(bus.res_taken), 32'(re.taken));
      chk({tag, ".res_mispredict"}, 32'(bus.res_mispredict), 32'(re.misp));
      chk({tag, ".res_redirect_pc"}, bus.res_redirect_pc, re.redirect);
    end
    chk({tag, ".mispredict_cnt"}, bus.mispredict_cnt, re.cnt);
    clear_inputs();
    q_pushed = 1'b0;
    r_pushed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pred_rvalid", 32'(bus.pred_rvalid), 32'd0);
    chk("reset.pred_target", bus.pred_target, 32'd0);
    chk("reset.res_done", 32'(bus.res_done), 32'd0);
    chk("reset.mispredict_cnt", bus.mispredict_cnt, 32'd0);
    rst = 1'b0;

    query(32'h100, 1'b0, 32'h104);                                        tick("cold_query");
    resolve(OP_BEQ, 32'd5, 32'd5, 32'h100, 32'h80, 1'b0, 32'h104, 1'b1); tick("beq_alloc");
    query(32'h100, 1'b1, 32'h80);                                         tick("query_hit");
    resolve(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h80, 1'b1, 32'h80, 1'b1); tick("blt_signed");
    resolve(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h80, 1'b1, 32'h80, 1'b0);
    query(32'h100, 1'b1, 32'h80);                                         tick("bltu_unsigned");
    query(32'h100, 1'b1, 32'h80);                                         tick("cnt_fell_to_2");
    for (int i = 0; i < 3; i++) begin
      resolve(OP_BNE, 32'd7, 32'd7, 32'h100, 32'h80, 1'b0, 32'h104, 1'b0);
      tick("bne_not_taken");
    end
    query(32'h100, 1'b0, 32'h104);                                        tick("cnt_saturated_0");
    resolve(OP_BGE, 32'd3, 32'd3, 32'h100, 32'h80, 1'b0, 32'h104, 1'b1); tick("bge_hit_taken");
    query(32'h100, 1'b0, 32'h104);                                        tick("tag_still_valid");

    resolve(OP_BEQ, 32'd1, 32'd1, 32'h200, 32'h300, 1'b0, 32'h204, 1'b1);
`ifdef BPU_FWD_EN
    query(32'h200, 1'b1, 32'h300);
`else
    query(32'h200, 1'b0, 32'h204);
`endif
    tick("same_cycle_fwd");
    query(32'h200, 1'b1, 32'h300);                                        tick("after_alloc_200");
    query(32'h100, 1'b0, 32'h104);                                        tick("evicted_100");
    resolve(OP_BGEU, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h10, 1'b1, 32'h10, 1'b0); tick("bgeu_cnt_sat");
    resolve(OP_NONE, 32'd1, 32'd1, 32'h40, 32'h10, 1'b1, 32'h10, 1'b0);  tick("no_op");
    query(32'h40, 1'b0, 32'h44);                                          tick("no_op_no_alloc");

    bus.flush = 1'b1;
    bus.pred_valid = 1'b1;
    bus.pred_pc = 32'h200;
    tick("flush");

    resolve(OP_BEQ, 32'd2, 32'd2, 32'h100, 32'h80, 1'b0, 32'h104, 1'b1);
    void'(res_q.pop_back());
    r_pushed = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid.res_done", 32'(bus.res_done), 32'd0);
    chk("rst_mid.res_redirect_pc", bus.res_redirect_pc, 32'd0);
    chk("rst_mid.mispredict_cnt", bus.mispredict_cnt, 32'd0);
    clear_inputs();
    rst = 1'b0;
    m_cnt = 32'd0;
    query(32'h200, 1'b0, 32'h204);                                        tick("rst_cleared_200");
    query(32'h100, 1'b0, 32'h104);                                        tick("rst_cleared_100");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
